// File: rtl/note_scheduler.sv
// note_scheduler: splits buffered note/rest events into measure-aligned power-of-two renderer writes
module note_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int MEASURES   = 20,
  parameter int GAP_CYCLES = 2
) (
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic       ev_valid_in,
  output logic       ev_ready_out,
  input  logic [5:0] ev_pitch_in,
  input  logic [5:0] ev_len_in,
  input  logic       ev_rest_in,
  input  logic       clear_in,
  output logic       new_note_out,
  output logic [5:0] note_out,
  output logic [7:0] note_type_out,
  output logic       tie_out,
  output logic       score_clr_out,
  output logic [7:0] eighth_pos_out,
  output logic       page_full_out,
  output logic       drop_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [7:0] FULL_POS = 8'(8 * MEASURES);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, EMIT, GAP, FULL} state_t;
  state_t state_q, state_d;
  logic [12:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [5:0] rem_q, rem_d, pitch_q, pitch_d, note_q, note_d;
  logic rest_q, rest_d, first_q, first_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] pos_q, pos_d, type_q, type_d;
  logic strobe_q, strobe_d, tie_q, tie_d, clr_q, clr_d, drop_q, drop_d;
  logic fifo_empty, fifo_full, push, pop;
  logic [12:0] head;
  logic [3:0] space, piece;
  logic [5:0] avail;
  logic [1:0] idx;
  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ev_ready_out = !fifo_full && state_q != FULL;
  // zero-length events are acknowledged but never occupy a slot
  assign push = ev_valid_in && ev_ready_out && ev_len_in != 6'd0;
  assign pop = state_q == LOAD;
  assign head = mem_q[rd_ptr_q[AW-1:0]];
  // largest power of two that fits both the remaining length and the room left in this measure
  assign space = 4'd8 - {1'b0, pos_q[2:0]};
  assign avail = (rem_q < {2'b00, space}) ? rem_q : {2'b00, space};
  assign idx = (avail >= 6'd8) ? 2'd3 : (avail >= 6'd4) ? 2'd2 : (avail >= 6'd2) ? 2'd1 : 2'd0;
  assign piece = 4'b0001 << idx;
  assign new_note_out = strobe_q;
  assign note_out = note_q;
  assign note_type_out = type_q;
  assign tie_out = tie_q;
  assign score_clr_out = clr_q;
  assign eighth_pos_out = pos_q;
  assign page_full_out = state_q == FULL;
  assign drop_out = drop_q;
  // event storage needs no reset: only slots between the pointers are ever read
  always_ff @(posedge pixel_clk_in) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ev_rest_in, ev_pitch_in, ev_len_in};
  end
  // sequencing: load an event, emit one piece, pace the renderer, repeat or stall on a full page
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    pitch_d = pitch_q;
    rest_d = rest_q;
    first_d = first_q;
    gap_d = gap_q;
    pos_d = pos_q;
    strobe_d = 1'b0;
    note_d = 6'd0;
    type_d = 8'd0;
    tie_d = 1'b0;
    drop_d = 1'b0;
    clr_d = clear_in;
    unique case (state_q)
      IDLE: state_d = fifo_empty ? IDLE : LOAD;
      LOAD: begin
        {rest_d, pitch_d, rem_d} = head;
        first_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        strobe_d = 1'b1;
        note_d = pitch_q;
        type_d = 8'b1 << {rest_q, idx};
        tie_d = !first_q && !rest_q;
        pos_d = pos_q + {4'b0000, piece};
        rem_d = rem_q - {2'b00, piece};
        first_d = 1'b0;
        gap_d = '0;
        state_d = GAP;
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          if (pos_q == FULL_POS && !clear_in) begin
            state_d = FULL;
            drop_d = rem_q != 6'd0;
            rem_d = 6'd0;
          end else begin
            state_d = (rem_q != 6'd0) ? EMIT : fifo_empty ? IDLE : LOAD;
          end
        end
      end
      FULL: state_d = FULL;
      default: state_d = IDLE;
    endcase
    if (clear_in) begin
      pos_d = 8'd0;
      if (state_q == FULL) state_d = IDLE;
    end
  end
  // state, pointers and registered renderer outputs
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rem_q <= 6'd0;
      pitch_q <= 6'd0;
      rest_q <= 1'b0;
      first_q <= 1'b0;
      gap_q <= '0;
      pos_q <= 8'd0;
      strobe_q <= 1'b0;
      note_q <= 6'd0;
      type_q <= 8'd0;
      tie_q <= 1'b0;
      clr_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      rem_q <= rem_d;
      pitch_q <= pitch_d;
      rest_q <= rest_d;
      first_q <= first_d;
      gap_q <= gap_d;
      pos_q <= pos_d;
      strobe_q <= strobe_d;
      note_q <= note_d;
      type_q <= type_d;
      tie_q <= tie_d;
      clr_q <= clr_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed and randomized checks of note_scheduler against a piece-list model
module tb_note_scheduler;
  logic clk = 1'b0, rst_n = 1'b1, valid = 1'b0, rest = 1'b0, clear = 1'b0;
  logic [5:0] pitch = 6'd0, len = 6'd0;
  logic ready, strobe, tie, score_clr, full, drop;
  logic [5:0] note;
  logic [7:0] note_type, pos;
  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, last_strobe = -100;
  typedef struct {logic [5:0] p; int len; bit r;} ev_t;
  ev_t mq[$];
  logic [14:0] exq[$], obq[$];
  int m_pos = 0, m_rem = 0, m_drops = 0, obs_drops = 0;
  logic [5:0] m_p = 6'd0;
  bit m_r = 0, m_first = 0, m_full = 0;

  note_scheduler dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .ev_valid_in(valid), .ev_ready_out(ready),
    .ev_pitch_in(pitch), .ev_len_in(len), .ev_rest_in(rest), .clear_in(clear),
    .new_note_out(strobe), .note_out(note), .note_type_out(note_type), .tie_out(tie),
    .score_clr_out(score_clr), .eighth_pos_out(pos), .page_full_out(full), .drop_out(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected piece list: split each event by the measure/power-of-two rule until the page fills
  task automatic model_run();
    int space, m, pc, idx;
    ev_t e;
    while (!m_full) begin
      if (m_rem == 0) begin
        if (mq.size() == 0) break;
        e = mq.pop_front();
        m_rem = e.len; m_p = e.p; m_r = e.r; m_first = 1;
      end
      space = 8 - (m_pos % 8);
      m = (m_rem < space) ? m_rem : space;
      pc = 1;
      while (pc * 2 <= m) pc = pc * 2;
      idx = $clog2(pc) + (m_r ? 4 : 0);
      exq.push_back({8'(1 << idx), !m_first && !m_r, m_r ? 6'd0 : m_p});
      m_first = 0;
      m_pos += pc;
      m_rem -= pc;
      if (m_pos == 160) begin
        m_full = 1;
        if (m_rem > 0) m_drops++;
        m_rem = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (strobe) begin
      chk("spacing", 32'(cyc - last_strobe >= 3), 32'd1);
      last_strobe = cyc;
      obq.push_back({note_type, tie, (|note_type[7:4]) ? 6'd0 : note});
    end else chk("idle_zero", 32'({note_type, tie, note}), 32'd0);
    if (drop) obs_drops++;
  end

  task automatic send(input logic [5:0] p, input logic [5:0] l, input bit r);
    int n = 0;
    @(negedge clk);
    valid = 1'b1; pitch = p; len = l; rest = r;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 500), 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    if (n < 500 && l != 6'd0) begin
      mq.push_back('{p, int'(l), r});
      model_run();
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("score_clr", 32'(score_clr), 32'd1);
    chk("clr_pos", 32'(pos), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    @(negedge clk);
    chk("score_clr_1cyc", 32'(score_clr), 32'd0);
    m_pos = 0; m_full = 0;
    model_run();
  endtask

  task automatic drain();
    int quiet = 0, n = 0;
    while (quiet < 12 && n < 3000) begin
      @(negedge clk);
      n++;
      quiet = strobe ? 0 : quiet + 1;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 32'(obq.size()), 32'(exq.size()));
    while (obq.size() > 0 && exq.size() > 0) chk(tag, 32'(obq.pop_front()), 32'(exq.pop_front()));
    obq.delete();
    exq.delete();
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({strobe, note, note_type, tie, score_clr, pos, full, drop}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    // T1: single two-eighth note, strobe exactly three cycles after acceptance
    send(6'h21, 6'd2, 1'b0);
    @(posedge clk); #1 chk("t1_lat1", 32'(strobe), 32'd0);
    @(posedge clk); #1 chk("t1_lat2", 32'(strobe), 32'd0);
    @(posedge clk); #1 chk("t1_lat3", 32'(strobe), 32'd1);
    chk("t1_word", 32'({note_type, tie, note}), 32'({8'h02, 1'b0, 6'h21}));
    drain();
    compare("t1");
    chk("t1_pos", 32'(pos), 32'd2);
    // T2: reach pos 6, then a five-eighth note split across the bar
    send(6'h10, 6'd4, 1'b0);
    send(6'h11, 6'd5, 1'b0);
    drain();
    chk("t2_n", 32'(obq.size()), 32'd4);
    chk("t2_p0", 32'(obq[0]), 32'({8'h04, 1'b0, 6'h10}));
    chk("t2_p1", 32'(obq[1]), 32'({8'h02, 1'b0, 6'h11}));
    chk("t2_p2", 32'(obq[2]), 32'({8'h02, 1'b1, 6'h11}));
    chk("t2_p3", 32'(obq[3]), 32'({8'h01, 1'b1, 6'h11}));
    compare("t2");
    chk("t2_pos", 32'(pos), 32'd11);
    // T3: whole-measure rest, then a zero-length event that must vanish
    do_clear();
    send(6'h07, 6'd8, 1'b1);
    drain();
    chk("t3_rest", 32'(obq[0]), 32'({8'h80, 1'b0, 6'h00}));
    compare("t3");
    chk("t3_pos", 32'(pos), 32'd8);
    send(6'h05, 6'd0, 1'b0);
    chk("t3_len0_ready", 32'(ready), 32'd1);
    drain();
    chk("t3_len0_none", 32'(obq.size()), 32'd0);
    chk("t3_len0_pos", 32'(pos), 32'd8);
    // random events that stay inside one page
    repeat (10) begin
      send(6'($urandom_range(0, 63)), 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    compare("rand");
    chk("rand_pos", 32'(pos), 32'(m_pos));
    // T4: fill to 156, an eight-eighth note overflows the page; two events wait behind it
    do_clear();
    send(6'h01, 6'd63, 1'b0);
    send(6'h02, 6'd63, 1'b1);
    send(6'h03, 6'd30, 1'b0);
    send(6'h04, 6'd8, 1'b0);
    send(6'h05, 6'd3, 1'b0);
    send(6'h06, 6'd2, 1'b1);
    drain();
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_pos", 32'(pos), 32'd160);
    chk("t4_ready", 32'(ready), 32'd0);
    chk("t4_drop", 32'(obs_drops), 32'd1);
    chk("t4_drop_model", 32'(obs_drops), 32'(m_drops));
    compare("t4");
    // T5: clearing a full page resumes the queued events
    do_clear();
    drain();
    compare("t5");
    chk("t5_pos", 32'(pos), 32'd5);
    chk("t5_full", 32'(full), 32'd0);
    chk("t5_ready", 32'(ready), 32'd1);
    // T6: nine back-to-back events overfill the buffer, then reset lands mid-gap
    do_clear();
    for (int i = 0; i < 9; i++) send(6'(i + 1), 6'd40, 1'b0);
    chk("t6_ready_low", 32'(ready), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!strobe && n < 100);
    chk("t6_strobe_seen", 32'(strobe), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_outputs", 32'({strobe, note, note_type, tie, score_clr, pos, full, drop}), 32'd0);
    while (obq.size() > 0 && exq.size() > 0) chk("t6_prefix", 32'(obq.pop_front()), 32'(exq.pop_front()));
    obq.delete(); exq.delete(); mq.delete();
    m_pos = 0; m_rem = 0; m_full = 0; m_drops = 0; obs_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", 32'(ready), 32'd1);
    chk("t6_pos_after", 32'(pos), 32'd0);
    send(6'h2a, 6'd1, 1'b0);
    drain();
    compare("t6_after");
    chk("t6_fifo_empty_pos", 32'(pos), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
